vga_timing_multi: RTL and testbench
===================================

VGA_TIMING_MULTI -- requirements
Module: vga_timing_multi

Interface
REQ-001 Parameter DEFAULT_MODE, default MODE_1024X768, meaning: timing mode loaded at reset.
REQ-002 Parameter CNT_W, default 11, meaning: width of the hcount/vcount counters.
REQ-003 Port clk, input, 1: single system clock, rising-edge active.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port ce, input, 1: pixel clock enable; the counters advance only on cycles where ce=1.
REQ-006 Port mode_sel, input, 2: requested timing mode (vga_mode_t).
REQ-007 Port vga_out, vga_if output modport: carries hcount, vcount, hsync, vsync, hblnk, vblnk.
REQ-008 Port frame_start, output, 1: one-cycle pulse when the counters enter (0,0).
REQ-009 Port mode_cur, output, 2: mode currently being generated.

Function
REQ-010 The block SHALL generate timing from the mode table; each entry holds h/v visible, front porch, sync, back porch, total, and sync polarity.
REQ-011 The mode table SHALL contain:
- MODE_1024X768: H 1024/24/136/160, total 1344; V 768/3/6/29, total 806; sync active-low.
- MODE_800X600: H 800/40/128/88, total 1056; V 600/1/4/23, total 628; sync active-high.
- MODE_640X480: H 640/16/96/48, total 800; V 480/10/2/33, total 525; sync active-low.
- mode_sel=3: reserved; treated as a request for MODE_1024X768.
REQ-012 On each ce=1 cycle, hcount SHALL increment; at htotal-1 it SHALL wrap to 0 and vcount SHALL increment.
REQ-013 vcount SHALL wrap from vtotal-1 to 0 on the same cycle that hcount wraps.
REQ-014 When ce=0, all outputs SHALL hold their values and frame_start SHALL be 0.
REQ-015 hblnk SHALL be 1 iff hcount >= hvisible; vblnk SHALL be 1 iff vcount >= vvisible.
REQ-016 hsync SHALL be active iff hvisible+hfp <= hcount < hvisible+hfp+hsync_len; vsync SHALL follow the same rule with the vertical values. Both SHALL apply the mode's polarity.
REQ-017 All vga_out signals SHALL be registered and cycle-aligned with each other: sync and blank reflect the hcount/vcount values presented on the same cycle.
REQ-018 frame_start SHALL be 1 for exactly one clk cycle: the cycle on which (hcount,vcount) becomes (0,0) after a ce=1 wrap.
REQ-019 A mode_sel change SHALL take effect only at a frame boundary: the new mode is sampled on the ce=1 cycle where hcount=htotal-1 and vcount=vtotal-1, and applies from the next (0,0).
REQ-020 mode_cur SHALL update on the same cycle the counters return to (0,0).
REQ-021 A mode_sel change mid-frame SHALL NOT alter the current frame's totals, sync positions or blanking.
REQ-022 If mode_sel changes several times within one frame, only the value present at the boundary sample SHALL apply.

Reset
REQ-023 While rst=1, regardless of ce, the outputs SHALL be: hcount=0, vcount=0, hblnk=0, vblnk=0, hsync and vsync at the inactive level of DEFAULT_MODE, frame_start=0, mode_cur=DEFAULT_MODE.
REQ-024 Reset asserted mid-frame SHALL abort the frame; counting SHALL restart at (0,0) in DEFAULT_MODE, with no frame_start pulse for that reset.
REQ-025 After rst deasserts, the first ce=1 cycle SHALL advance hcount to 1.

Structure
REQ-026 The following SHALL live in vga_pkg: vga_mode_t (enum), the timing-entry struct, the mode table constant, and CNT_W.
REQ-027 The counter/mode-latch logic and the sync/blank decode SHALL share one always_ff domain on clk.
REQ-028 Sub-module vga_mode_lut (combinational: mode in, timing struct out) SHALL be instantiated once.

Verification
REQ-029 ce=1, rst pulse, DEFAULT_MODE:
- hcount reaches 1343 then 0; vcount wraps 805 to 0.
- hsync is low exactly for hcount 1048..1183; vsync is low for vcount 771..776.
- frame_start is seen once per 1344*806 cycles.
REQ-030 mode_sel=1 at hcount=500, vcount=300:
- The current frame finishes at 1344x806.
- The next frame has htotal 1056 and vtotal 628, with hsync high for hcount 840..967.
- mode_cur becomes 1 together with frame_start.
REQ-031 ce toggled 1-of-2 cycles:
- Frame length is 2*1344*806 clk cycles.
- Outputs are stable on ce=0 cycles.
REQ-032 rst asserted at hcount=700, vcount=400 with mode_cur=2:
- Next cycle: counters are 0, mode_cur=0, frame_start=0.
REQ-033 mode_sel=3 requested:
- It behaves as MODE_1024X768.
- mode_sel 1 then 2 within one frame applies only 2.
REQ-034 Concurrent assertions SHALL check, on every ce=1 cycle:
- hcount < htotal and vcount < vtotal.
- hblnk equals (hcount >= hvisible).
- frame_start implies hcount==0 and vcount==0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing types: mode enum, per-mode timing entry, the mode table and lookup helpers.
package vga_pkg;

    localparam int unsigned CNT_W = 11;

    typedef enum logic [1:0] {
        MODE_1024X768 = 2'd0,
        MODE_800X600  = 2'd1,
        MODE_640X480  = 2'd2,
        MODE_RSVD     = 2'd3
    } vga_mode_t;

    typedef struct packed {
        logic [CNT_W-1:0] h_vis;
        logic [CNT_W-1:0] h_fp;
        logic [CNT_W-1:0] h_sync;
        logic [CNT_W-1:0] h_bp;
        logic [CNT_W-1:0] h_total;
        logic [CNT_W-1:0] v_vis;
        logic [CNT_W-1:0] v_fp;
        logic [CNT_W-1:0] v_sync;
        logic [CNT_W-1:0] v_bp;
        logic [CNT_W-1:0] v_total;
        logic             sync_pol;   // 1: sync pulses are active-high
    } vga_timing_t;

    localparam vga_timing_t VGA_MODE_TABLE [3] = '{
        '{h_vis: CNT_W'(1024), h_fp: CNT_W'(24), h_sync: CNT_W'(136), h_bp: CNT_W'(160),
          h_total: CNT_W'(1344), v_vis: CNT_W'(768), v_fp: CNT_W'(3), v_sync: CNT_W'(6),
          v_bp: CNT_W'(29), v_total: CNT_W'(806), sync_pol: 1'b0},
        '{h_vis: CNT_W'(800), h_fp: CNT_W'(40), h_sync: CNT_W'(128), h_bp: CNT_W'(88),
          h_total: CNT_W'(1056), v_vis: CNT_W'(600), v_fp: CNT_W'(1), v_sync: CNT_W'(4),
          v_bp: CNT_W'(23), v_total: CNT_W'(628), sync_pol: 1'b1},
        '{h_vis: CNT_W'(640), h_fp: CNT_W'(16), h_sync: CNT_W'(96), h_bp: CNT_W'(48),
          h_total: CNT_W'(800), v_vis: CNT_W'(480), v_fp: CNT_W'(10), v_sync: CNT_W'(2),
          v_bp: CNT_W'(33), v_total: CNT_W'(525), sync_pol: 1'b0}
    };

    // The reserved encoding falls back to the 1024x768 timing.
    function automatic vga_mode_t vga_mode_resolve(input vga_mode_t m);
        return (m == MODE_RSVD) ? MODE_1024X768 : m;
    endfunction

    function automatic vga_timing_t vga_lookup(input vga_mode_t m);
        case (m)
            MODE_800X600: return VGA_MODE_TABLE[1];
            MODE_640X480: return VGA_MODE_TABLE[2];
            default:      return VGA_MODE_TABLE[0];
        endcase
    endfunction

    function automatic logic vga_sync_pol(input vga_mode_t m);
        vga_timing_t t;
        t = vga_lookup(m);
        return t.sync_pol;
    endfunction

endpackage

// File: rtl/vga_if.sv
// Raster position and sync/blank bundle produced by the timing generator.
interface vga_if #(
    parameter int unsigned CNT_W = vga_pkg::CNT_W
);
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vga_mode_lut.sv
// Combinational mode-to-timing lookup.
module vga_mode_lut
    import vga_pkg::*;
(
    input  vga_mode_t   mode,
    output vga_timing_t timing
);

    assign timing = vga_lookup(mode);

endmodule

// File: rtl/vga_timing_multi.sv
// Multi-mode VGA timing generator; mode changes are latched only at the frame boundary.
module vga_timing_multi #(
    parameter vga_pkg::vga_mode_t DEFAULT_MODE = vga_pkg::MODE_1024X768,
    parameter int unsigned        CNT_W        = vga_pkg::CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [1:0] mode_sel,
    vga_if.out         vga_out,
    output logic       frame_start,
    output logic [1:0] mode_cur
);

    vga_pkg::vga_mode_t   mode_q;
    vga_pkg::vga_mode_t   mode_nxt;
    vga_pkg::vga_timing_t tim;

    logic [CNT_W-1:0] hcount_q;
    logic [CNT_W-1:0] vcount_q;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             hsync_q, vsync_q, hblnk_q, vblnk_q;
    logic             h_last, v_last, wrap;
    logic             pol_nxt, hact_nxt, vact_nxt;
    logic             unused_bp;

    vga_mode_lut u_lut (
        .mode   (mode_q),
        .timing (tim)
    );

    // Back porch is implied by the totals.
    assign unused_bp = ^{tim.h_bp, tim.v_bp};

    // Next raster position and its decode; at a wrap the new mode's polarity takes over.
    always_comb begin
        h_last   = (hcount_q == CNT_W'(tim.h_total - 1'b1));
        v_last   = (vcount_q == CNT_W'(tim.v_total - 1'b1));
        wrap     = h_last && v_last;
        h_nxt    = h_last ? '0 : CNT_W'(hcount_q + 1'b1);
        v_nxt    = vcount_q;
        if (h_last) begin
            v_nxt = v_last ? '0 : CNT_W'(vcount_q + 1'b1);
        end
        mode_nxt = wrap ? vga_pkg::vga_mode_resolve(vga_pkg::vga_mode_t'(mode_sel)) : mode_q;
        pol_nxt  = vga_pkg::vga_sync_pol(mode_nxt);
        hact_nxt = (h_nxt >= CNT_W'(tim.h_vis + tim.h_fp)) &&
                   (h_nxt <  CNT_W'(tim.h_vis + tim.h_fp + tim.h_sync));
        vact_nxt = (v_nxt >= CNT_W'(tim.v_vis + tim.v_fp)) &&
                   (v_nxt <  CNT_W'(tim.v_vis + tim.v_fp + tim.v_sync));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q    <= '0;
            vcount_q    <= '0;
            hblnk_q     <= 1'b0;
            vblnk_q     <= 1'b0;
            hsync_q     <= ~vga_pkg::vga_sync_pol(DEFAULT_MODE);
            vsync_q     <= ~vga_pkg::vga_sync_pol(DEFAULT_MODE);
            frame_start <= 1'b0;
            mode_q      <= vga_pkg::vga_mode_resolve(DEFAULT_MODE);
        end else begin
            frame_start <= 1'b0;
            if (ce) begin
                hcount_q    <= h_nxt;
                vcount_q    <= v_nxt;
                hblnk_q     <= (h_nxt >= CNT_W'(tim.h_vis));
                vblnk_q     <= (v_nxt >= CNT_W'(tim.v_vis));
                hsync_q     <= hact_nxt ~^ pol_nxt;
                vsync_q     <= vact_nxt ~^ pol_nxt;
                frame_start <= wrap;
                mode_q      <= mode_nxt;
            end
        end
    end

    assign vga_out.hcount = hcount_q;
    assign vga_out.vcount = vcount_q;
    assign vga_out.hsync  = hsync_q;
    assign vga_out.vsync  = vsync_q;
    assign vga_out.hblnk  = hblnk_q;
    assign vga_out.vblnk  = vblnk_q;
    assign mode_cur       = mode_q;

endmodule

// File: tb/tb_vga_timing_multi.sv
// Bench for vga_timing_multi: two instances (1024x768 and 800x600 defaults) against a raster model.
module tb_vga_timing_multi;

    localparam int NCYC = 40000;

    localparam int HVIS [3] = '{1024, 800, 640};
    localparam int HFP  [3] = '{24, 40, 16};
    localparam int HSY  [3] = '{136, 128, 96};
    localparam int HTOT [3] = '{1344, 1056, 800};
    localparam int VVIS [3] = '{768, 600, 480};
    localparam int VFP  [3] = '{3, 1, 10};
    localparam int VSY  [3] = '{6, 4, 2};
    localparam int VTOT [3] = '{806, 628, 525};
    localparam int POL  [3] = '{0, 1, 0};
    localparam int DFLT [2] = '{0, 1};

    logic       clk = 1'b0;
    logic       rst, ce;
    logic [1:0] mode_sel;
    logic       fs0, fs1;
    logic [1:0] mc0, mc1;

    vga_if vif0 ();
    vga_if vif1 ();

    vga_timing_multi dut0 (
        .clk(clk), .rst(rst), .ce(ce), .mode_sel(mode_sel),
        .vga_out(vif0), .frame_start(fs0), .mode_cur(mc0)
    );

    vga_timing_multi #(.DEFAULT_MODE(vga_pkg::MODE_800X600)) dut1 (
        .clk(clk), .rst(rst), .ce(ce), .mode_sel(mode_sel),
        .vga_out(vif1), .frame_start(fs1), .mode_cur(mc1)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Raster model state per instance.
    int md [2];
    int hm [2];
    int vm [2];
    bit fsm [2];

    function automatic int midx(input logic [1:0] m);
        return (m == 2'd1) ? 1 : (m == 2'd2) ? 2 : 0;
    endfunction

    function automatic bit sync_lvl(input int m, input int pos, input int start, input int len);
        bit act;
        act = (pos >= start) && (pos < start + len);
        return (POL[m] != 0) ? act : !act;
    endfunction

    task automatic model_step(input int i, input bit r, input bit c, input logic [1:0] s);
        if (r) begin
            md[i] = DFLT[i]; hm[i] = 0; vm[i] = 0; fsm[i] = 0;
        end else begin
            fsm[i] = 0;
            if (c) begin
                hm[i]++;
                if (hm[i] == HTOT[md[i]]) begin
                    hm[i] = 0;
                    vm[i]++;
                    if (vm[i] == VTOT[md[i]]) begin
                        vm[i] = 0;
                        md[i] = (s == 2'd3) ? 0 : int'(s);
                        fsm[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d: observed %0d, expected %0d (h=%0d v=%0d)", tag, i, obs, exp, hm[i], vm[i]);
        end
    endtask

    task automatic compare_one(input int i, input logic [10:0] hc, input logic [10:0] vc,
                               input logic hs, input logic vs, input logic hb, input logic vb,
                               input logic fs, input logic [1:0] mc);
        int m;
        m = md[i];
        check("hcount", i, 32'(hc), 32'(hm[i]));
        check("vcount", i, 32'(vc), 32'(vm[i]));
        check("hsync",  i, 32'(hs), 32'(sync_lvl(m, hm[i], HVIS[m] + HFP[m], HSY[m])));
        check("vsync",  i, 32'(vs), 32'(sync_lvl(m, vm[i], VVIS[m] + VFP[m], VSY[m])));
        check("hblnk",  i, 32'(hb), 32'(hm[i] >= HVIS[m]));
        check("vblnk",  i, 32'(vb), 32'(vm[i] >= VVIS[m]));
        check("frame_start", i, 32'(fs), 32'(fsm[i]));
        check("mode_cur", i, 32'(mc), 32'(m));
    endtask

    // Invariants on every enabled cycle.
    a_range0: assert property (@(posedge clk) disable iff (rst)
        ce |-> (int'(vif0.hcount) < HTOT[midx(mc0)]) && (int'(vif0.vcount) < VTOT[midx(mc0)]))
        else begin miscompares++; $error("FAIL range dut0: h=%0d v=%0d", vif0.hcount, vif0.vcount); end
    a_blank0: assert property (@(posedge clk) disable iff (rst)
        ce |-> vif0.hblnk == (int'(vif0.hcount) >= HVIS[midx(mc0)]))
        else begin miscompares++; $error("FAIL hblnk_inv dut0: hblnk=%0b h=%0d", vif0.hblnk, vif0.hcount); end
    a_fs0: assert property (@(posedge clk) disable iff (rst)
        ce && fs0 |-> vif0.hcount == 0 && vif0.vcount == 0)
        else begin miscompares++; $error("FAIL fs_origin dut0: h=%0d v=%0d", vif0.hcount, vif0.vcount); end
    a_range1: assert property (@(posedge clk) disable iff (rst)
        ce |-> (int'(vif1.hcount) < HTOT[midx(mc1)]) && (int'(vif1.vcount) < VTOT[midx(mc1)]))
        else begin miscompares++; $error("FAIL range dut1: h=%0d v=%0d", vif1.hcount, vif1.vcount); end
    a_blank1: assert property (@(posedge clk) disable iff (rst)
        ce |-> vif1.hblnk == (int'(vif1.hcount) >= HVIS[midx(mc1)]))
        else begin miscompares++; $error("FAIL hblnk_inv dut1: hblnk=%0b h=%0d", vif1.hblnk, vif1.hcount); end
    a_fs1: assert property (@(posedge clk) disable iff (rst)
        ce && fs1 |-> vif1.hcount == 0 && vif1.vcount == 0)
        else begin miscompares++; $error("FAIL fs_origin dut1: h=%0d v=%0d", vif1.hcount, vif1.vcount); end

    initial begin
        bit         r, c;
        logic [1:0] s;
        rst = 1'b1; ce = 1'b0; mode_sel = 2'd0;
        s = 2'd0;
        model_step(0, 1'b1, 1'b0, s);
        model_step(1, 1'b1, 1'b0, s);
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            compare_one(0, vif0.hcount, vif0.vcount, vif0.hsync, vif0.vsync,
                        vif0.hblnk, vif0.vblnk, fs0, mc0);
            compare_one(1, vif1.hcount, vif1.vcount, vif1.hsync, vif1.vsync,
                        vif1.hblnk, vif1.vblnk, fs1, mc1);
            if (cyc < 3) begin
                // reset holds regardless of ce
                r = 1'b1; c = bit'($urandom_range(0, 1));
            end else if (cyc < 3000) begin
                r = 1'b0; c = 1'b1;
            end else if (cyc < 9000) begin
                r = 1'b0; c = (cyc % 2 == 0);
            end else if (cyc == 20000) begin
                r = 1'b1; c = 1'b0;
            end else begin
                r = ($urandom_range(0, 3999) == 0);
                c = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 49) == 0) begin
                s = 2'($urandom_range(0, 3));
            end
            rst = r; ce = c; mode_sel = s;
            model_step(0, r, c, s);
            model_step(1, r, c, s);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
